// File: rtl/boa_pmu_ctl.sv
// boa_pmu_ctl: power-management sequencer between the board buttons / PMU
// request lines and the SoC reset and clock-gate.
//  - Debounces the raw reset and wake buttons (2-flop sync + stability count).
//  - Stretches every reset to exactly RST_CYCLES cycles.
//  - Sequences shutdown with a SHDN_GUARD cycle delay.
//  - Records the cause of the last reset.
// Optional watchdog: define BOA_PMU_WDT_EN to build it in.
// The FSM state is exported on the state port for observation.
module boa_pmu_ctl #(
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned SHDN_GUARD = 4,
    parameter int unsigned WDT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_rst_raw,
    input  logic       btn_wake_raw,
    input  logic       req_rst,
    input  logic       req_shdn,
    input  logic       wdt_kick,
    output logic       core_rst,
    output logic       core_shdn,
    output logic [1:0] state,
    output logic [2:0] rst_cause
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_RUN       = 2'd1,
        ST_SHDN_PEND = 2'd2,
        ST_SHDN      = 2'd3
    } state_t;

    localparam logic [2:0] CAUSE_POR  = 3'd0;
    localparam logic [2:0] CAUSE_BTN  = 3'd1;
    localparam logic [2:0] CAUSE_SW   = 3'd2;
    localparam logic [2:0] CAUSE_WAKE = 3'd3;
    localparam logic [2:0] CAUSE_WDT  = 3'd4;

    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    localparam int unsigned CNT_MAX = (RST_CYCLES > SHDN_GUARD) ? RST_CYCLES : SHDN_GUARD;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(SHDN_GUARD - 1);

    // Index 0 is the reset button, index 1 the wake button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     db_lvl;
    logic [1:0]     db_hit;
    logic [DBW-1:0] db_cnt [2];

    logic           btn_rst_evt;
    logic           wake_evt;
    logic           wdt_exp;

    state_t         cur_st;
    state_t         nxt_st;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [2:0]     cause_nxt;

    assign btn_raw = {btn_wake_raw, btn_rst_raw};

    // Two-flop synchronisers for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // A debounced level flips on the edge its stability count completes.
    always_comb begin
        db_hit = '0;
        for (int i = 0; i < 2; i++) begin
            db_hit[i] = (sync_b[i] != db_lvl[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Stability counters: cleared whenever the synced level agrees with the debounced one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_lvl <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    db_lvl[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Only the rising edge of a debounced level is an event.
    assign btn_rst_evt = db_hit[0] & sync_b[0];
    assign wake_evt    = db_hit[1] & sync_b[1];

`ifdef BOA_PMU_WDT_EN
    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);
    logic [31:0] wdt_cnt;

    assign wdt_exp = (cur_st == ST_RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

    // Watchdog runs only in RUN; any kick, expiry or other state clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if ((cur_st != ST_RUN) || wdt_kick || wdt_exp) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_exp = 1'b0;
`endif

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st    <= ST_RESET;
            cnt       <= '0;
            rst_cause <= CAUSE_POR;
            core_rst  <= 1'b1;
            core_shdn <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            cnt       <= cnt_nxt;
            rst_cause <= cause_nxt;
            core_rst  <= (nxt_st == ST_RESET);
            core_shdn <= (nxt_st == ST_SHDN);
        end
    end

    // Next state with fixed priority BTN > SW > WDT > WAKE > shutdown.
    always_comb begin
        nxt_st    = cur_st;
        cnt_nxt   = cnt;
        cause_nxt = rst_cause;
        case (cur_st)
            ST_RESET: begin
                if (btn_rst_evt) begin
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (req_rst) begin
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_SW;
                end else if (cnt == RST_LAST) begin
                    nxt_st  = ST_RUN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (btn_rst_evt) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (req_rst) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_SW;
                end else if (wdt_exp) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_WDT;
                end else if (req_shdn) begin
                    nxt_st  = ST_SHDN_PEND;
                    cnt_nxt = '0;
                end
            end
            ST_SHDN_PEND: begin
                if (btn_rst_evt) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (req_rst) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_SW;
                end else if (cnt == GUARD_LAST) begin
                    nxt_st  = ST_SHDN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_SHDN: begin
                if (btn_rst_evt) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (req_rst) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_SW;
                end else if (wake_evt) begin
                    nxt_st    = ST_RESET;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_WAKE;
                end
            end
            default: begin
                nxt_st  = ST_RESET;
                cnt_nxt = '0;
            end
        endcase
    end

    assign state = cur_st;

endmodule

// File: tb/tb_boa_pmu_ctl.sv
// Bench for boa_pmu_ctl: directed scenarios followed by random stimulus,
// every cycle compared against a reference model of the sequencer rules.
module tb_boa_pmu_ctl;

    localparam int DB    = 8;
    localparam int RSTC  = 16;
    localparam int GUARD = 4;
    localparam int WDT   = 64;
`ifdef BOA_PMU_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_rst_raw;
    logic       btn_wake_raw;
    logic       req_rst;
    logic       req_shdn;
    logic       wdt_kick;
    logic       core_rst;
    logic       core_shdn;
    logic [1:0] state;
    logic [2:0] rst_cause;

    boa_pmu_ctl #(
        .DB_CYCLES (DB),
        .RST_CYCLES(RSTC),
        .SHDN_GUARD(GUARD),
        .WDT_CYCLES(WDT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_rst_raw (btn_rst_raw),
        .btn_wake_raw(btn_wake_raw),
        .req_rst     (req_rst),
        .req_shdn    (req_shdn),
        .wdt_kick    (wdt_kick),
        .core_rst    (core_rst),
        .core_shdn   (core_shdn),
        .state       (state),
        .rst_cause   (rst_cause)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // reference model: states 0 RESET, 1 RUN, 2 SHDN_PEND, 3 SHDN
    int m_state, m_left, m_cause, cyc_n, m_wdt_base;
    bit m_db_r, m_db_w;
    bit hist_r[$], hist_w[$], win_r[$], win_w[$];

    task automatic model_reset();
        m_state = 0; m_left = RSTC - 1; m_cause = 0;
        cyc_n = 0; m_wdt_base = 0;
        m_db_r = 0; m_db_w = 0;
        hist_r.delete(); hist_w.delete(); win_r.delete(); win_w.delete();
        exp_q.delete();
    endtask

    function automatic int ones(input bit q[$]);
        int c = 0;
        foreach (q[i]) c += int'(q[i]);
        return c;
    endfunction

    task automatic enter_reset(input int c);
        m_state = 0; m_left = RSTC - 1; m_cause = c;
    endtask

    // One rising edge of the model, using the inputs the DUT samples.
    task automatic model_step();
        bit s_r, s_w, ev_r, ev_w, fire;
        // synchronised level is the raw level two edges back
        s_r = (hist_r.size() >= 2) ? hist_r[0] : 1'b0;
        s_w = (hist_w.size() >= 2) ? hist_w[0] : 1'b0;
        hist_r.push_back(btn_rst_raw);  if (hist_r.size() > 2) void'(hist_r.pop_front());
        hist_w.push_back(btn_wake_raw); if (hist_w.size() > 2) void'(hist_w.pop_front());
        // debounced level flips once the last DB samples all disagree with it
        win_r.push_back(s_r); if (win_r.size() > DB) void'(win_r.pop_front());
        win_w.push_back(s_w); if (win_w.size() > DB) void'(win_w.pop_front());
        ev_r = 0; ev_w = 0;
        if (win_r.size() == DB) begin
            if (!m_db_r && ones(win_r) == DB) begin m_db_r = 1; ev_r = 1; end
            else if (m_db_r && ones(win_r) == 0) m_db_r = 0;
        end
        if (win_w.size() == DB) begin
            if (!m_db_w && ones(win_w) == DB) begin m_db_w = 1; ev_w = 1; end
            else if (m_db_w && ones(win_w) == 0) m_db_w = 0;
        end
        fire = WDT_ON && (m_state == 1) && !wdt_kick && (cyc_n - m_wdt_base == WDT - 1);
        if (m_state != 1 || wdt_kick || fire) m_wdt_base = cyc_n + 1;
        case (m_state)
            0: begin
                if (ev_r) enter_reset(1);
                else if (req_rst) enter_reset(2);
                else if (m_left == 0) m_state = 1;
                else m_left--;
            end
            1: begin
                if (ev_r) enter_reset(1);
                else if (req_rst) enter_reset(2);
                else if (fire) enter_reset(4);
                else if (req_shdn) begin m_state = 2; m_left = GUARD - 1; end
            end
            2: begin
                if (ev_r) enter_reset(1);
                else if (req_rst) enter_reset(2);
                else if (m_left == 0) m_state = 3;
                else m_left--;
            end
            default: begin
                if (ev_r) enter_reset(1);
                else if (req_rst) enter_reset(2);
                else if (ev_w) enter_reset(3);
            end
        endcase
        cyc_n++;
        exp_q.push_back({2'(m_state), m_state == 0, m_state == 3, 3'(m_cause)});
    endtask

    // observation counters for the directed scenarios
    int  rst_rises = 0;
    int  swap_cnt  = 0;
    bit  shdn_seen = 0;
    bit  prev_rst  = 1;
    bit  prev_shdn = 0;

    // driver: one clock cycle, model on the rising edge, compare on the falling edge
    task automatic cyc();
        logic [6:0] e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e = exp_q.pop_front();
        check("state",     state,     e[6:5]);
        check("core_rst",  core_rst,  e[4]);
        check("core_shdn", core_shdn, e[3]);
        check("rst_cause", rst_cause, e[2:0]);
        if (core_rst && !prev_rst) rst_rises++;
        if (prev_shdn && !core_shdn && core_rst) swap_cnt++;
        if (core_shdn) shdn_seen = 1;
        prev_rst  = core_rst;
        prev_shdn = core_shdn;
    endtask

    task automatic run_until_state(input string tag, input int target, input int max, output int n);
        n = 0;
        while (state != 2'(target) && n < max) begin
            cyc();
            n++;
        end
        check(tag, state, target);
    endtask

    initial begin
        int n, r0, s0, r_left, w_left;
        rst = 1; btn_rst_raw = 0; btn_wake_raw = 0;
        req_rst = 0; req_shdn = 0; wdt_kick = 0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_state",     state,     0);
            check("rst_core_rst",  core_rst,  1);
            check("rst_core_shdn", core_shdn, 0);
            check("rst_cause0",    rst_cause, 0);
        end
        rst = 0;

        // power-on reset width
        run_until_state("por_reach_run", 1, 40, n);
        check("por_width", n, RSTC);
        check("por_cause", rst_cause, 0);

        // software reset pulse
        req_rst = 1; cyc(); req_rst = 0;
        check("sw_rst_next_edge", core_rst, 1);
        run_until_state("sw_reach_run", 1, 40, n);
        check("sw_rst_width", n, RSTC);
        check("sw_cause", rst_cause, 2);

        // bouncing reset button, then a sustained press
        r0 = rst_rises;
        for (int i = 0; i < 40; i++) begin
            btn_rst_raw = ((i / 3) % 2) == 1;
            cyc();
        end
        check("bounce_no_reset", rst_rises - r0, 0);
        btn_rst_raw = 1;
        repeat (12) cyc();
        repeat (40) cyc();
        check("btn_one_reset", rst_rises - r0, 1);
        check("btn_cause", rst_cause, 1);
        btn_rst_raw = 0;
        repeat (12) cyc();
        run_until_state("btn_reach_run", 1, 40, n);

        // shutdown with guard, then wake
        req_shdn = 1; cyc();
        check("pend_entered", state, 2);
        run_until_state("shdn_reach", 3, 20, n);
        check("guard_len", n, GUARD);
        check("shdn_gate", core_shdn, 1);
        repeat (5) cyc();
        req_shdn = 0;
        s0 = swap_cnt;
        btn_wake_raw = 1;
        repeat (12) cyc();
        btn_wake_raw = 0;
        check("wake_swap", swap_cnt - s0, 1);
        check("wake_cause", rst_cause, 3);
        repeat (12) cyc();
        run_until_state("wake_reach_run", 1, 40, n);

        // reset request cancels a pending shutdown
        shdn_seen = 0;
        req_shdn = 1; cyc();
        req_shdn = 0; cyc();
        req_rst = 1; cyc(); req_rst = 0;
        check("cancel_state", state, 0);
        check("cancel_cause", rst_cause, 2);
        run_until_state("cancel_reach_run", 1, 40, n);
        check("cancel_no_shdn", shdn_seen, 0);

        // watchdog: regular kicks, then none
        r0 = rst_rises;
        for (int i = 0; i < 500; i++) begin
            wdt_kick = (i % 50) == 0;
            cyc();
        end
        wdt_kick = 0;
        check("wdt_kicked_no_reset", rst_rises - r0, 0);
        r0 = rst_rises;
        repeat (80) cyc();
        check("wdt_expiry_resets", rst_rises - r0, WDT_ON ? 1 : 0);
        check("wdt_cause", rst_cause, WDT_ON ? 4 : 2);

        // random stimulus
        r_left = 0; w_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (r_left == 0) begin
                btn_rst_raw = ($urandom_range(0, 3) == 0);
                r_left = $urandom_range(1, 20);
            end
            if (w_left == 0) begin
                btn_wake_raw = ($urandom_range(0, 2) == 0);
                w_left = $urandom_range(1, 20);
            end
            r_left--; w_left--;
            req_rst  = ($urandom_range(0, 63) == 0);
            req_shdn = ($urandom_range(0, 7) == 0);
            wdt_kick = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/boa_pmu_ctl.md
Name: boa_pmu_ctl

Overview:
- Power-management sequencer between the board's buttons and the core's PMU request lines (req_rst / req_shdn) on one side, and the SoC reset and clock-gate on the other.
- Debounces the raw reset and wake buttons.
- Stretches every reset to a guaranteed minimum width and sequences shutdown with a guard delay.
- Records the cause of the last reset for software; optionally runs a watchdog.

Parameters:
- DB_CYCLES, 1000000, cycles a synchronised button level must hold stable before the debounced level changes (10 ms at 100 MHz); >= 1.
- RST_CYCLES, 16, exact width of core_rst in clk cycles; >= 1.
- SHDN_GUARD, 4, cycles from accepted shutdown request to core_shdn assertion; >= 1.
- WDT_CYCLES, 100000000, watchdog timeout in cycles (only used with BOA_PMU_WDT_EN).

Ports:
- clk  in  1  system clock; never gated by this block.
- rst  in  1  asynchronous, active-high reset.
- btn_rst_raw  in  1  raw reset button, asynchronous, active-high.
- btn_wake_raw  in  1  raw wake button, asynchronous, active-high.
- req_rst  in  1  software reset request from the PMU bus; level, sampled each cycle.
- req_shdn  in  1  software shutdown request from the PMU bus; level, sampled each cycle.
- wdt_kick  in  1  watchdog kick pulse; ignored unless BOA_PMU_WDT_EN.
- core_rst  out  1  registered reset to the SoC.
- core_shdn  out  1  registered clock-gate enable; 1 means the SoC clock is stopped.
- state  out  2  current state: 0 RESET, 1 RUN, 2 SHDN_PEND, 3 SHDN.
- rst_cause  out  3  cause of the last reset: 0 POR, 1 BTN, 2 SW, 3 WAKE, 4 WDT.

Behaviour:
- Reset (rst=1, async):
  - state=RESET; core_rst=1; core_shdn=0; rst_cause=0.
  - All counters 0; debounced levels 0; synchronisers cleared.
- Button path:
  - Each raw button passes a 2-flop synchroniser, then a stability counter.
  - The counter resets on any change of the synchronised level versus the debounced level.
  - When the counter reaches DB_CYCLES-1 with the level still different, the debounced level updates on that edge.
  - Only the rising edge of a debounced level is an event. Holding a button does not re-trigger.
- RESET:
  - core_rst=1, core_shdn=0; the counter increments every cycle.
  - When the counter reaches RST_CYCLES-1: go to RUN, and core_rst falls on that edge. core_rst is therefore high for exactly RST_CYCLES cycles.
  - A new reset event while in RESET restarts the counter and updates rst_cause.
- RUN, in priority order:
  - Button-reset event -> RESET, cause 1.
  - req_rst -> RESET, cause 2.
  - Watchdog expiry -> RESET, cause 4.
  - req_shdn -> SHDN_PEND.
  - State and outputs change on the same edge the event is sampled, so core_rst rises 1 cycle after req_rst is seen high.
- SHDN_PEND:
  - Counts SHDN_GUARD cycles, then enters SHDN, and core_shdn rises on that edge.
  - Any reset event (button or req_rst) cancels the shutdown -> RESET, with core_shdn remaining 0.
  - req_shdn deasserting does not cancel.
- SHDN:
  - core_shdn=1, core_rst=0.
  - Wake event -> RESET with cause 3. Button-reset event -> RESET with cause 1. req_rst -> RESET with cause 2.
  - On that edge core_shdn falls and core_rst rises together.
  - req_shdn is ignored.
- Simultaneous events:
  - The priority is fixed: BTN > SW > WDT > WAKE > shutdown.
  - A wake event outside SHDN is discarded.
- rst_cause is held until the next reset entry. It is not cleared by leaving RESET.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: BOA_PMU_WDT_EN.
- With the macro defined:
  - A 32-bit watchdog counter runs only in RUN.
  - The counter is cleared in every other state and on any cycle with wdt_kick=1.
  - When the counter reaches WDT_CYCLES-1 without a kick: -> RESET, cause 4.
- Without the macro: no watchdog logic; wdt_kick is ignored and cause 4 never occurs.

Test Plan (DB_CYCLES=8, RST_CYCLES=16, SHDN_GUARD=4, WDT_CYCLES=64):
- POR: assert rst, then release -> core_rst=1 for exactly 16 edges, then state=1, core_rst=0, rst_cause=0.
- In RUN, pulse req_rst for 1 cycle -> core_rst high on the next edge for 16 cycles; rst_cause=2.
- In RUN:
  - Bounce btn_rst_raw every 3 cycles for 40 cycles -> no reset.
  - Then hold it high 12 cycles -> exactly one reset; rst_cause=1.
  - Keep holding -> no second reset.
- In RUN, req_shdn=1:
  - state=2 for 4 cycles, then state=3, core_shdn=1.
  - Then hold btn_wake_raw 12 cycles -> core_shdn=0 and core_rst=1 on the same edge; rst_cause=3.
- In SHDN_PEND, on the 2nd guard cycle pulse req_rst -> core_shdn never asserts; state=0; rst_cause=2.
- BOA_PMU_WDT_EN:
  - Kicks every 50 cycles for 500 cycles -> no reset.
  - Stop kicking -> reset after 64 cycles; rst_cause=4.
  - Without the macro, the same no-kick stimulus -> no reset.
